host_cmd_queue: RTL and testbench



---
 rtl/mpu_cmd_pkg.sv | 35 +++
 rtl/cmd_fifo.sv | 76 +++++++
 rtl/host_cmd_queue.sv | 136 +++++++++++++
 tb/tb_host_cmd_queue.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mpu_cmd_pkg
// Description : Shared definitions for the matrix-unit host command path:
//               the no-op instruction value, the instruction field layout,
//               the no-op class test and the issuer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mpu_cmd_pkg;

  // Value driven to the control FSM whenever nothing is being issued.
  localparam logic [7:0] NOP_INSTR = 8'h00;

  // Instruction layout {DD[7:6], AA[5:4], op[3:0]}.
  typedef struct packed {
    logic [1:0] dd;
    logic [1:0] aa;
    logic [3:0] op;
  } instr_t;

  // Issuer states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } issue_state_e;

  // Opcodes whose upper two op bits are zero form the no-op class.
  function automatic logic is_nop_class(input instr_t instr);
    return (instr.op[3:2] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cmd_fifo
// Description : Synchronous FIFO with a combinational head read, an extra
//               pointer bit to tell full from empty, and a synchronous flush.
// Ports       : clk, reset_n  - clock, asynchronous active-low reset
//               push_i/wdata_i - write request and data (ignored when full)
//               pop_i          - advance the head (ignored when empty)
//               flush_i        - empty the FIFO; a push this cycle is dropped
//               full_o/empty_o - occupancy flags
//               level_o        - entries held
//               rdata_o        - current head entry
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [WIDTH-1:0]         rdata_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_en;
  logic             rd_en;

  // Pointers carry one extra wrap bit, so their difference is the level.
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == (AW + 1)'(DEPTH));
  assign empty_o = (level_o == '0);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_en = push_i && !full_o && !flush_i;
  assign rd_en = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/host_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : host_cmd_queue
// Description : Buffers host instructions, drops no-op class commands and
//               issues each queued instruction to the matrix-unit control FSM
//               for one cycle, then waits for the FSM busy handshake (rise
//               then fall) before issuing the next. A missing busy response
//               within ACK_TIMEOUT cycles sets a sticky error and drops the
//               instruction.
// Ports       : clk, reset_n        - clock, asynchronous active-low reset
//               cmd_valid/cmd_data  - host push (valid/ready)
//               cmd_ready           - queue not full
//               flush               - clear queue and error flag
//               fsm_busy            - busy from the control FSM
//               host_instruction    - registered instruction, 8'h00 when idle
//               issued              - one-cycle issue pulse
//               level               - entries held
//               ack_err             - sticky busy-timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module host_cmd_queue
  import mpu_cmd_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  input  logic [7:0]             cmd_data,
  output logic                   cmd_ready,
  input  logic                   flush,
  input  logic                   fsm_busy,
  output logic [7:0]             host_instruction,
  output logic                   issued,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ack_err
);

  localparam int              CW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0]   TMO_LAST = CW'(ACK_TIMEOUT - 1);

  issue_state_e    state_q, state_d;
  logic [7:0]      instr_q, instr_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic            err_q, err_d;

  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      fifo_head;
  logic            push;
  logic            pop;

  assign cmd_ready = !fifo_full;

  // No-op class commands are accepted (handshake completes) but never stored.
  assign push = cmd_valid && cmd_ready && !flush && !is_nop_class(instr_t'(cmd_data));

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .wdata_i (cmd_data),
    .pop_i   (pop),
    .flush_i (flush),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level),
    .rdata_o (fifo_head)
  );

  always_comb begin
    state_d = state_q;
    instr_d = NOP_INSTR;
    tmo_d   = tmo_q;
    err_d   = err_q;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !fsm_busy && !flush) begin
          pop     = 1'b1;
          instr_d = fifo_head;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (fsm_busy) begin
          tmo_d   = '0;
          state_d = ST_WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          // Give up on this instruction; it is not retried.
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!fsm_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush takes priority over a timeout landing on the same edge.
    if (flush) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      instr_q <= NOP_INSTR;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign host_instruction = instr_q;
  assign issued           = (state_q == ST_ISSUE);
  assign ack_err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_host_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_host_cmd_queue
// Description : Self-checking bench for host_cmd_queue: a directed vector
//               table, hand-written multi-cycle sequences and a randomized
//               run, all compared every cycle against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_host_cmd_queue;

  localparam int DEPTH       = 4;
  localparam int ACK_TIMEOUT = 4;
  localparam int LW          = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [7:0]    cmd_data = 8'h00;
  logic          flush = 1'b0;
  logic          fsm_busy = 1'b0;
  logic          cmd_ready;
  logic [7:0]    host_instruction;
  logic          issued;
  logic [LW-1:0] level;
  logic          ack_err;

  always #5 clk = ~clk;

  host_cmd_queue #(
    .DEPTH       (DEPTH),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cmd_valid        (cmd_valid),
    .cmd_data         (cmd_data),
    .cmd_ready        (cmd_ready),
    .flush            (flush),
    .fsm_busy         (fsm_busy),
    .host_instruction (host_instruction),
    .issued           (issued),
    .level            (level),
    .ack_err          (ack_err)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // phase: 0 waiting to issue, 1 issuing, 2 awaiting busy, 3 awaiting release
  logic [7:0] mq[$];
  int         m_phase;
  logic [7:0] m_out;
  int         m_wait;
  bit         m_err;

  // busy responder: raises busy for resp_len cycles starting one cycle after issue
  bit auto_busy = 1'b0;
  int resp_len  = 1;
  int busy_rem  = 0;

  int         cyc = 0;
  logic [7:0] issue_log[$];
  int         issue_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase  = 0;
    m_out    = 8'h00;
    m_wait   = 0;
    m_err    = 1'b0;
    busy_rem = 0;
  endtask

  task automatic model_edge();
    bit accept;
    accept = cmd_valid && (mq.size() < DEPTH);
    case (m_phase)
      0: if (mq.size() != 0 && !fsm_busy && !flush) begin
           m_out   = mq.pop_front();
           m_phase = 1;
         end
      1: begin m_phase = 2; m_out = 8'h00; m_wait = 0; end
      2: if (fsm_busy) m_phase = 3;
         else begin
           m_wait++;
           if (m_wait == ACK_TIMEOUT) begin m_err = 1'b1; m_phase = 0; end
         end
      default: if (!fsm_busy) m_phase = 0;
    endcase
    if (flush) begin
      mq.delete();
      m_err = 1'b0;
    end else if (accept && cmd_data[3:2] != 2'b00) begin
      mq.push_back(cmd_data);
    end
  endtask

  function automatic logic [31:0] exp_vec();
    logic [7:0] hi;
    hi = (m_phase == 1) ? m_out : 8'h00;
    return 32'({hi, (m_phase == 1), LW'(mq.size()), (mq.size() < DEPTH), m_err});
  endfunction

  function automatic logic [31:0] act_vec();
    return 32'({host_instruction, issued, level, cmd_ready, ack_err});
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check($sformatf("cycle%0d outputs", cyc), act_vec(), exp_vec());
    if (issued === 1'b1) begin
      issue_log.push_back(host_instruction);
      issue_cyc.push_back(cyc);
    end
    if (auto_busy) begin
      if (m_phase == 1) begin busy_rem = resp_len; fsm_busy = 1'b0; end
      else if (busy_rem > 0) begin fsm_busy = 1'b1; busy_rem--; end
      else fsm_busy = 1'b0;
    end
  endtask

  task automatic push(input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_issues(input string name, input int n, input int budget);
    for (int i = 0; i < budget && issue_log.size() < n; i++) tick();
    check({name, " issue count"}, issue_log.size(), n);
  endtask

  task automatic settle(input int budget);
    for (int i = 0; i < budget && !(m_phase == 0 && busy_rem == 0 && !fsm_busy); i++) tick();
    tick();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          v;
    logic [7:0]  d;
    bit          f;
    bit          b;
    logic [7:0]  hi;
    bit          iss;
    logic [2:0]  lvl;
    bit          rdy;
    bit          err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq_a[5];
    seq_a = '{8'h14, 8'h28, 8'h3C, 8'h44, 8'h58};

    // push ADD, watch issue/handshake, then a no-op class push
    tbl[0] = '{1'b1, 8'h1C, 1'b0, 1'b0, 8'h00, 1'b0, 3'd1, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h1C, 1'b1, 3'd0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset state", act_vec(), 32'({8'h00, 1'b0, 3'd0, 1'b1, 1'b0}));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      cmd_valid = tbl[i].v;
      cmd_data  = tbl[i].d;
      flush     = tbl[i].f;
      fsm_busy  = tbl[i].b;
      tick();
      check($sformatf("table row %0d", i), act_vec(),
            32'({tbl[i].hi, tbl[i].iss, tbl[i].lvl, tbl[i].rdy, tbl[i].err}));
    end
    cmd_valid = 1'b0;
    fsm_busy  = 1'b0;

    // fill past capacity while busy, then drain in order
    fsm_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_data  = seq_a[i];
      tick();
      if (i == 3) check("full after 4th push", 32'({cmd_ready, level}), 32'({1'b0, 3'd4}));
    end
    cmd_valid = 1'b0;
    check("5th push rejected", 32'(level), 32'd4);
    issue_log.delete();
    issue_cyc.delete();
    fsm_busy  = 1'b0;
    auto_busy = 1'b1;
    resp_len  = 1;
    wait_issues("drain", 4, 60);
    for (int k = 0; k < 4 && k < issue_log.size(); k++)
      check($sformatf("drain order %0d", k), issue_log[k], seq_a[k]);
    for (int k = 1; k < 4 && k < issue_cyc.size(); k++)
      check($sformatf("drain spacing %0d", k), issue_cyc[k] - issue_cyc[k-1], 4);
    settle(20);

    // long busy: LOAD holds busy 66 cycles
    issue_log.delete();
    issue_cyc.delete();
    resp_len = 66;
    push(8'h44);
    push(8'h1C);
    wait_issues("long busy", 2, 200);
    if (issue_log.size() == 2) begin
      check("long busy first", issue_log[0], 8'h44);
      check("long busy second", issue_log[1], 8'h1C);
      check("long busy spacing", issue_cyc[1] - issue_cyc[0], 69);
    end
    settle(200);

    // busy never rises: timeout, next entry still issues, flush clears error
    auto_busy = 1'b0;
    fsm_busy  = 1'b0;
    issue_log.delete();
    issue_cyc.delete();
    push(8'h2C);
    push(8'h34);
    wait_issues("timeout", 2, 40);
    if (issue_cyc.size() == 2) begin
      check("timeout spacing", issue_cyc[1] - issue_cyc[0], 6);
      check("ack_err after timeout", ack_err, 1'b1);
    end
    settle(20);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush clears ack_err", ack_err, 1'b0);

    // asynchronous reset during ISSUE with 3 entries left
    fsm_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(seq_a[i]);
    fsm_busy = 1'b0;
    tick();
    check("pre-reset issue", 32'({issued, level}), 32'({1'b1, 3'd3}));
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset", act_vec(), 32'({8'h00, 1'b0, 3'd0, 1'b1, 1'b0}));
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // randomized traffic with a responder of random latency (0 = never)
    auto_busy = 1'b1;
    issue_log.delete();
    issue_cyc.delete();
    for (int i = 0; i < 800; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_data  = 8'($urandom);
      flush     = ($urandom_range(0, 19) == 0);
      resp_len  = $urandom_range(0, 4);
      tick();
    end
    cmd_valid = 1'b0;
    flush     = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
